// File: rtl/cmp_seq_arb_if.sv
// Bus bundle between two compare requesters, the result consumer and the
// shared 8-bit cascaded comparator. The slave view belongs to the sequencer.
interface cmp_seq_arb_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_signed;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_signed;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic             rsp_eq;
  logic             rsp_gt;
  logic             rsp_lt;
  logic [7:0]       cmp_a;
  logic [7:0]       cmp_b;
  logic             cmp_eq_in;
  logic             cmp_gt_in;
  logic             cmp_eq_out;
  logic             cmp_gt_out;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_signed,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_signed,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt,
    input  rsp_ready,
    output cmp_a, cmp_b, cmp_eq_in, cmp_gt_in,
    input  cmp_eq_out, cmp_gt_out
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_signed,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_signed,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt,
    output rsp_ready,
    input  cmp_a, cmp_b, cmp_eq_in, cmp_gt_in,
    output cmp_eq_out, cmp_gt_out
  );
endinterface

// File: rtl/cmp_seq_arb.sv
// Round-robin sequencer for the shared 8-bit cascaded comparator. A granted
// WIDTH-bit compare is fed one slice per cycle, MSB first, stopping at the
// first differing slice; the result is held until the consumer takes it.
module cmp_seq_arb #(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          resetn,
  cmp_seq_arb_if.slave bus
);
  localparam int NSLICE = WIDTH / 8;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             eq_acc;
  logic             gt_acc;
  logic             ptr;      // 1 = requester 1 wins a tie
  logic             id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic             gnt0;
  logic             gnt1;
  logic             msb_flip;

  // Select slice idx of v; flip inverts bit 7 so an unsigned compare of the
  // MSB slice yields two's-complement order.
  function automatic logic [7:0] slice_of(input logic [WIDTH-1:0] v,
                                          input logic [CNT_W-1:0] idx,
                                          input logic flip);
    logic [WIDTH-1:0] sh;
    sh = v >> {idx, 3'b000};
    return sh[7:0] ^ {flip, 7'b0};
  endfunction

  // Arbitration: only in IDLE and out of reset; the pointer breaks ties.
  always_comb begin
    gnt0 = resetn && (state == IDLE) && bus.req0_valid && (!bus.req1_valid || !ptr);
    gnt1 = resetn && (state == IDLE) && bus.req1_valid && (!bus.req0_valid || ptr);
    bus.req0_ready = gnt0;
    bus.req1_ready = gnt1;
  end

  // Comparator drive: the current latched slice and cascade inputs while running.
  always_comb begin
    msb_flip      = sgn_q && (cnt == CNT_TOP);
    bus.cmp_a     = '0;
    bus.cmp_b     = '0;
    bus.cmp_eq_in = 1'b0;
    bus.cmp_gt_in = 1'b0;
    if (state == RUN) begin
      bus.cmp_a     = slice_of(a_q, cnt, msb_flip);
      bus.cmp_b     = slice_of(b_q, cnt, msb_flip);
      bus.cmp_eq_in = eq_acc;
      bus.cmp_gt_in = gt_acc;
    end
  end

  // Operand capture on acceptance; requesters are free to change them afterwards.
  always_ff @(posedge clock) begin
    if (gnt0 || gnt1) begin
      a_q   <= gnt1 ? bus.req1_a      : bus.req0_a;
      b_q   <= gnt1 ? bus.req1_b      : bus.req0_b;
      sgn_q <= gnt1 ? bus.req1_signed : bus.req0_signed;
    end
  end

  // Sequencer FSM: accept, walk slices MSB first, hold result until taken.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= CNT_TOP;
      eq_acc        <= 1'b1;
      gt_acc        <= 1'b0;
      ptr           <= 1'b0;
      id_q          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_eq    <= 1'b0;
      bus.rsp_gt    <= 1'b0;
      bus.rsp_lt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            id_q   <= gnt1;
            ptr    <= !gnt1;
            eq_acc <= 1'b1;
            gt_acc <= 1'b0;
            cnt    <= CNT_TOP;
            state  <= RUN;
          end
        end
        RUN: begin
          eq_acc <= bus.cmp_eq_out;
          gt_acc <= bus.cmp_gt_out;
          if (!bus.cmp_eq_out || (cnt == '0)) begin
            state         <= DONE;
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= id_q;
            bus.rsp_eq    <= bus.cmp_eq_out;
            bus.rsp_gt    <= bus.cmp_gt_out;
            bus.rsp_lt    <= !bus.cmp_eq_out && !bus.cmp_gt_out;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_eq    <= 1'b0;
            bus.rsp_gt    <= 1'b0;
            bus.rsp_lt    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
